ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; sends one command byte from the CPU side to the keyboard (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset).
- Sits beside the PS/2 keyboard receiver on the same PS2_CLK/PS2_DATA pair.
- Drives both lines open-drain (low or released) and reports completion, ACK or error.
- Asserts rx_inhibit while it owns the bus so the receiver discards the traffic.

Parameters:
- INHIBIT_CYCLES, 10000: CLK100MHZ cycles the clock line is held low before request-to-send (100 us).
- TIMEOUT_CYCLES, 1500000: maximum CLK100MHZ cycles from clock release to ACK completion (15 ms).
- SYNC_STAGES, 2: synchronizer flops on ps2_clk_in and ps2_data_in (minimum 2).

Ports:
- CLK100MHZ  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- ps2_clk_in  input  1  sensed PS2_CLK line.
- ps2_data_in  input  1  sensed PS2_DATA line.
- ps2_clk_drv_low  output  1  1 = pull PS2_CLK low; 0 = release.
- ps2_data_drv_low  output  1  1 = pull PS2_DATA low; 0 = release.
- tx_data  input  8  command byte, sampled when tx_start is accepted.
- tx_start  input  1  one-cycle request; accepted only when busy=0.
- busy  output  1  high from the accepting cycle until done or error.
- done  output  1  one-cycle pulse when the device ACKs.
- tx_err  output  1  one-cycle pulse on NACK or timeout.
- err_code  output  2  00 none, 01 NACK, 10 timeout; held until the next accepted tx_start.
- rx_inhibit  output  1  equals busy.

Behaviour:
- Clock and reset: CLK100MHZ, reset asynchronous and active-high.
- Reset values: all outputs 0, both lines released, state IDLE, counters 0. Reset during any state aborts the transfer immediately with no done or tx_err pulse.
- Synchronization: both line inputs pass through SYNC_STAGES flops. A falling edge is synchronized clk = 0 while the previous synchronized value was 1.
- Frame: shift register holds {stop=1, parity=~^tx_data, tx_data}, latched at accept. Parity is odd.
- IDLE:
  - On tx_start with busy=0: latch the frame, clear err_code, busy=1, go to INHIBIT.
  - tx_start while busy=1 is ignored. The byte is lost and no status changes.
- INHIBIT: clk_drv_low=1 for INHIBIT_CYCLES cycles, then go to RTS.
- RTS:
  - First cycle: data_drv_low=1 (start bit); clk_drv_low stays 1.
  - Next cycle: clk_drv_low=0, start the timeout counter, go to DATA.
- DATA: on each falling edge n (1..10), present frame bit n-1 on the data line (data_drv_low = ~bit), LSB first.
  - Edges 1-8 carry D0-D7, edge 9 carries parity, edge 10 carries stop (release).
  - After edge 10, go to ACK.
- ACK: on the next falling edge (edge 11), sample data.
  - 0: ACK, go to WAIT_IDLE.
  - 1: err_code=01, tx_err pulse, busy=0, go to IDLE.
- WAIT_IDLE: when synchronized clk=1 and data=1 on the same cycle, pulse done, busy=0, go to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES in DATA, ACK or WAIT_IDLE:
  - release both lines, err_code=10, tx_err pulse, busy=0, go to IDLE.
- Edge counter: 4 bits, cleared at accept. done and tx_err never assert on the same cycle.
- Latency: done arrives at least INHIBIT_CYCLES+2 cycles after tx_start; the rest is set by the device clock (10-16.7 kHz).

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - On NACK or timeout, if the retry count is below 2: increment it and restart from INHIBIT with the same latched frame. busy stays 1 and there is no tx_err pulse.
  - The third failure reports as normal, with err_code set by the last failure.
  - The retry count clears at accept.
- Not defined: the first failure is reported immediately and there is no retry logic.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz that drives ACK low:
  - line bits after the start bit are 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - one done pulse, busy falls, err_code=00.
- Send 0xF4 with ACK: data bits 0,0,1,0,1,1,1,1, parity 0; done pulses once.
- Device leaves data high on the 11th clock -> tx_err pulses, err_code=01. With PS2_TX_RETRY_EN, three full frames are seen first.
- No device clocks after RTS -> tx_err and err_code=10 exactly TIMEOUT_CYCLES cycles after clock release; both lines released.
- Check clock hold at start: clk_drv_low is held exactly INHIBIT_CYCLES cycles before data_drv_low rises.
- Second tx_start (0x55) during an 0xED transfer: only 0xED is transmitted.
- Assert reset at edge 5 -> busy=0, both drive outputs 0 within one cycle, no done or tx_err.
- Next tx_start after that reset transmits correctly.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command sender; open-drain drive, done >= INHIBIT_CYCLES+2 cycles after accept, rest paced by device clock.
// tx_start while busy is dropped; PS2_TX_RETRY_EN re-sends the latched frame up to twice on NACK/timeout before reporting.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drv_low,
    output logic       ps2_data_drv_low,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       tx_err,
    output logic [1:0] err_code,
    output logic       rx_inhibit
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, DATA, ACK, WAIT_IDLE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             bit_q, bit_d;
    logic [9:0]             frame_q, frame_d;
    logic                   data_low_q, data_low_d;
    logic [1:0]             err_q, err_d;
    logic                   done_q, done_d;
    logic                   tx_err_q, tx_err_d;
    logic                   fail;
    logic [1:0]             fail_code;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]             retry_q, retry_d;
`endif

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev;
    logic                   clk_s, data_s, clk_fall;

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign clk_fall = clk_prev & ~clk_s;

    // Sync chains reset to the released (high) level so no edge is seen after reset.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
            clk_prev  <= clk_s;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            frame_q    <= '0;
            data_low_q <= 1'b0;
            err_q      <= 2'b00;
            done_q     <= 1'b0;
            tx_err_q   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            frame_q    <= frame_d;
            data_low_q <= data_low_d;
            err_q      <= err_d;
            done_q     <= done_d;
            tx_err_q   <= tx_err_d;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        frame_d    = frame_q;
        data_low_d = data_low_q;
        err_d      = err_q;
        done_d     = 1'b0;
        tx_err_d   = 1'b0;
        fail       = 1'b0;
        fail_code  = 2'b00;
`ifdef PS2_TX_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    frame_d = {1'b1, ~^tx_data, tx_data};
                    err_d   = 2'b00;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d = 2'd0;
`endif
                end
            end
            INHIBIT: begin
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_d      = '0;
                    data_low_d = 1'b1;
                    state_d    = RTS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RTS: begin
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA, ACK, WAIT_IDLE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    fail      = 1'b1;
                    fail_code = 2'b10;
                end else if (state_q == DATA) begin
                    if (clk_fall) begin
                        data_low_d = ~frame_q[bit_q];
                        bit_d      = bit_q + 4'd1;
                        if (bit_q == 4'd9) state_d = ACK;
                    end
                end else if (state_q == ACK) begin
                    if (clk_fall) begin
                        if (!data_s) begin
                            state_d = WAIT_IDLE;
                        end else begin
                            fail      = 1'b1;
                            fail_code = 2'b01;
                        end
                    end
                end else if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fail) begin
            cnt_d      = '0;
            bit_d      = '0;
            data_low_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_q != 2'd2) begin
                retry_d = retry_q + 2'd1;
                state_d = INHIBIT;
            end else begin
                err_d    = fail_code;
                tx_err_d = 1'b1;
                state_d  = IDLE;
            end
`else
            err_d    = fail_code;
            tx_err_d = 1'b1;
            state_d  = IDLE;
`endif
        end
    end

    assign ps2_clk_drv_low  = (state_q == INHIBIT) || (state_q == RTS);
    assign ps2_data_drv_low = data_low_q;
    assign busy             = (state_q != IDLE);
    assign rx_inhibit       = busy;
    assign done             = done_q;
    assign tx_err           = tx_err_q;
    assign err_code         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model plus a PS/2 device model clocking at a scaled-down rate.
module tb_ps2_host_tx;
    localparam int INH   = 50;
    localparam int TO    = 2000;
    localparam int HALF  = 20;
    localparam int LIMIT = 20000;
`ifdef PS2_TX_RETRY_EN
    localparam int TRIES = 3;
`else
    localparam int TRIES = 1;
`endif

    typedef struct packed {
        logic       ok;
        logic [1:0] code;
    } res_t;

    logic       CLK100MHZ = 1'b0;
    logic       reset = 1'b1;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_drv_low, ps2_data_drv_low;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       busy, done, tx_err, rx_inhibit;
    logic [1:0] err_code;

    int checks = 0, failures = 0;
    int done_cnt = 0, err_cnt = 0;
    int d0 = 0, e0 = 0;
    bit ab;
    logic [9:0] frame_q[$];
    res_t       res_q[$];

    assign ps2_clk_in  = ~(ps2_clk_drv_low | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_drv_low | dev_data_low);

    always #5 CLK100MHZ = ~CLK100MHZ;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES(2)
    ) dut (
        .CLK100MHZ(CLK100MHZ),
        .reset(reset),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_drv_low(ps2_clk_drv_low),
        .ps2_data_drv_low(ps2_data_drv_low),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .busy(busy),
        .done(done),
        .tx_err(tx_err),
        .err_code(err_code),
        .rx_inhibit(rx_inhibit)
    );

    always @(negedge CLK100MHZ) begin
        if (done) done_cnt++;
        if (tx_err) err_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Frame as it should appear on the wire, D0 first: data, odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0), b};
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge CLK100MHZ);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge CLK100MHZ);
        tx_start = 1'b0;
    endtask

    task automatic device_frame(input bit ack, input bit chk_inh, input int abort_edge, output bit aborted);
        int n = 0;
        int inh = 0;
        logic [9:0] got = '0;
        logic [9:0] exp;
        aborted = 1'b0;
        while (!(ps2_clk_in && !ps2_data_in) && n < LIMIT) begin
            if (ps2_clk_drv_low && !ps2_data_drv_low) inh++;
            @(negedge CLK100MHZ);
            n++;
        end
        check("start_seen", int'(n < LIMIT), 1);
        if (n >= LIMIT) return;
        if (chk_inh) check("inhibit_len", inh, INH);
        repeat (HALF) @(negedge CLK100MHZ);
        for (int e = 1; e <= 10; e++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge CLK100MHZ);
            if (e == abort_edge) begin
                aborted = 1'b1;
                return;
            end
            dev_clk_low = 1'b0;
            got[e-1] = ps2_data_in;
            repeat (HALF) @(negedge CLK100MHZ);
        end
        exp = (frame_q.size() > 0) ? frame_q.pop_front() : 10'h000;
        check("frame_bits", int'(got), int'(exp));
        dev_data_low = ack;
        repeat (HALF / 2) @(negedge CLK100MHZ);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge CLK100MHZ);
        dev_clk_low = 1'b0;
        repeat (HALF / 2) @(negedge CLK100MHZ);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        res_t exp;
        #1;
        while (done_cnt == d0 && err_cnt == e0 && n < LIMIT) begin
            @(negedge CLK100MHZ);
            #1;
            n++;
        end
        check("end_seen", int'(n < LIMIT), 1);
        repeat (5) @(negedge CLK100MHZ);
        #1;
        exp = (res_q.size() > 0) ? res_q.pop_front() : 3'b000;
        check("done_pulses", done_cnt - d0, int'(exp.ok));
        check("err_pulses", err_cnt - e0, int'(!exp.ok));
        check("err_code", int'(err_code), int'(exp.code));
        check("busy_low", int'(busy), 0);
        check("rx_inhibit_low", int'(rx_inhibit), 0);
    endtask

    initial begin
        repeat (3) @(negedge CLK100MHZ);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_tx_err", int'(tx_err), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_clk_drv", int'(ps2_clk_drv_low), 0);
        check("rst_data_drv", int'(ps2_data_drv_low), 0);
        check("rst_rx_inhibit", int'(rx_inhibit), 0);
        reset = 1'b0;
        repeat (5) @(negedge CLK100MHZ);

        // 0xED with ACK
        d0 = done_cnt; e0 = err_cnt;
        frame_q.push_back(model_frame(8'hED));
        res_q.push_back('{1'b1, 2'b00});
        send(8'hED);
        device_frame(1'b1, 1'b1, 0, ab);
        wait_end();

        // 0xED again with a 0x55 request arriving mid-transfer
        d0 = done_cnt; e0 = err_cnt;
        frame_q.push_back(model_frame(8'hED));
        res_q.push_back('{1'b1, 2'b00});
        send(8'hED);
        repeat (10) @(negedge CLK100MHZ);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge CLK100MHZ);
        tx_start = 1'b0;
        check("busy_during", int'(busy), 1);
        check("rx_inhibit_during", int'(rx_inhibit), 1);
        device_frame(1'b1, 1'b0, 0, ab);
        wait_end();
        repeat (2 * INH) @(negedge CLK100MHZ);
        check("no_late_start", int'(busy), 0);

        // 0xF4 with ACK
        d0 = done_cnt; e0 = err_cnt;
        frame_q.push_back(model_frame(8'hF4));
        res_q.push_back('{1'b1, 2'b00});
        send(8'hF4);
        device_frame(1'b1, 1'b1, 0, ab);
        wait_end();

        // NACK: device leaves data high on the 11th clock
        d0 = done_cnt; e0 = err_cnt;
        for (int a = 0; a < TRIES; a++) frame_q.push_back(model_frame(8'hFF));
        res_q.push_back('{1'b0, 2'b01});
        send(8'hFF);
        for (int a = 0; a < TRIES; a++) device_frame(1'b0, (a == 0), 0, ab);
        wait_end();

        // Timeout: nobody clocks after request-to-send
        d0 = done_cnt; e0 = err_cnt;
        res_q.push_back('{1'b0, 2'b10});
        send(8'hF4);
        for (int a = 0; a < TRIES; a++) begin
            int n = 0;
            while (!(!ps2_clk_drv_low && ps2_data_drv_low) && n < LIMIT) begin
                @(negedge CLK100MHZ);
                n++;
            end
            check("release_seen", int'(n < LIMIT), 1);
            n = 0;
            while (!tx_err && !ps2_clk_drv_low && n < LIMIT) begin
                @(negedge CLK100MHZ);
                n++;
            end
            check("timeout_len", n, TO);
        end
        check("to_tx_err", int'(tx_err), 1);
        check("to_clk_released", int'(ps2_clk_drv_low), 0);
        check("to_data_released", int'(ps2_data_drv_low), 0);
        wait_end();

        // Reset asserted at the 5th device clock
        d0 = done_cnt; e0 = err_cnt;
        frame_q.push_back(model_frame(8'hED));
        send(8'hED);
        device_frame(1'b1, 1'b1, 5, ab);
        check("abort_reached", int'(ab), 1);
        @(negedge CLK100MHZ);
        reset = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_clk_drv", int'(ps2_clk_drv_low), 0);
        check("abort_data_drv", int'(ps2_data_drv_low), 0);
        frame_q.delete();
        dev_clk_low = 1'b0;
        @(negedge CLK100MHZ);
        reset = 1'b0;
        repeat (50) @(negedge CLK100MHZ);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_err", err_cnt - e0, 0);

        // First transfer after that reset
        d0 = done_cnt; e0 = err_cnt;
        frame_q.push_back(model_frame(8'hF4));
        res_q.push_back('{1'b1, 2'b00});
        send(8'hF4);
        device_frame(1'b1, 1'b1, 0, ab);
        wait_end();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
